mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Memory-access and writeback stage directly downstream of the ALU stage. It accepts one completed ALU operation per transfer. Loads and stores go through a valid/ready data-memory port with variable latency, and a response timeout aborts a stuck access. The stage drives the register-file write port and backpressures the ALU stage while a memory access is outstanding.

Parameters:
DATA_W, 16, datapath width
ADDR_W, 8, data-memory address width; uses alu_result[ADDR_W-1:0]
TIMEOUT, 32, maximum cycles in REQ+RESP before the access is aborted (>=2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU stage presents an operation
in_ready  out  1  stage can accept an operation this cycle
in_opcode  in  4  0000 lw, 0001 sw, 0100 add, 0101 sub, 1000 addi
in_rd  in  4  destination register
in_alu_result  in  DATA_W  ALU result or effective address
in_store_data  in  DATA_W  rs2 data for sw
in_pc  in  8  pc of the operation
dmem_req  out  1  memory request valid
dmem_ready  in  1  memory accepts the request
dmem_we  out  1  1 = store
dmem_addr  out  ADDR_W  request address
dmem_wdata  out  DATA_W  store data
dmem_rvalid  in  1  load data valid
dmem_rdata  in  DATA_W  load data
wb_en  out  1  register-file write enable (one-cycle pulse)
wb_addr  out  4  register-file write address
wb_data  out  DATA_W  register-file write data
wb_pc  out  8  pc of the retiring operation
err_timeout  out  1  one-cycle pulse when an access is aborted
err_illegal  out  1  one-cycle pulse when an unknown opcode is dropped

Behaviour:
- Reset (asynchronous, active-low): state goes to IDLE and the timeout counter clears. dmem_req, dmem_we, wb_en, err_timeout and err_illegal are 0. All address, data and pc outputs are 0. A mid-access reset drops dmem_req immediately and produces no writeback.
- States: IDLE, REQ, RESP. in_ready = (state==IDLE), driven combinationally. A transfer occurs when in_valid && in_ready.
- IDLE with add/sub/addi: the next cycle drives wb_en=1, wb_addr=in_rd, wb_data=in_alu_result, wb_pc=in_pc. Latency is 1 and state stays IDLE, so back-to-back ALU ops retire every cycle.
- IDLE with lw or sw: latch address, rd, pc and store data, then go to REQ. Outputs are registered, so dmem_req rises in the cycle after the transfer. dmem_we=1 for sw and 0 for lw.
- REQ: hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable until dmem_ready. On dmem_req && dmem_ready:
  - sw: go to IDLE and drop dmem_req in the next cycle. No writeback.
  - lw without dmem_rvalid in the same cycle: go to RESP and drop dmem_req.
  - lw with dmem_rvalid in the same cycle: complete exactly as in RESP.
- RESP: on dmem_rvalid, go to IDLE. The next cycle drives wb_en=1, wb_addr=latched rd, wb_data=dmem_rdata, wb_pc=latched pc.
- dmem_rvalid in IDLE, or in REQ for a store, is ignored.
- Timeout: the counter clears on entering REQ and increments each cycle in REQ or RESP. If it reaches TIMEOUT-1 without completion, the stage:
  - aborts and goes to IDLE;
  - drops dmem_req;
  - pulses err_timeout for one cycle;
  - produces no writeback.
  Completion in the same cycle as the limit takes priority over the abort.
- Register 0: any writeback with rd==0 is suppressed (wb_en stays 0). wb_data still updates.
- Unknown opcode accepted in IDLE: dropped, no writeback, err_illegal pulses the next cycle, state stays IDLE.
- wb_en and error pulses last exactly one cycle. wb_addr, wb_data and wb_pc hold their last values otherwise.
- Addition/width: no arithmetic in this stage. dmem_addr is truncated to the low ADDR_W bits of in_alu_result.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants OP_LW=4'b0000, OP_SW=4'b0001, OP_ADD=4'b0100, OP_SUB=4'b0101, OP_ADDI=4'b1000;
  - state enum mem_state_t {IDLE, REQ, RESP};
  - REG_ZERO=4'd0.
- One sub-module, mem_timeout_ctr (clear/enable/expired, width $clog2(TIMEOUT)). Everything else stays flat.

Test Plan:
- Back-to-back ALU ops: add rd=3 result=16'h0005, then sub rd=4 result=16'hFFFF on consecutive cycles -> wb_en high 2 consecutive cycles, (3,0005) then (4,FFFF), in_ready always 1.
- lw rd=5 addr=16'h0130, memory ready after 2 cycles and rvalid 3 cycles later with 16'h000B -> dmem_addr=8'h30, we=0, in_ready low throughout, one wb (5,000B) the cycle after rvalid.
- sw addr=8'h31 data=16'h1234, ready immediately -> dmem_req one cycle with we=1, wdata=1234, no wb_en, in_ready back to 1 the next cycle.
- lw with ready and rvalid in the same cycle, rdata=16'hBEEF, rd=0 -> returns to IDLE, wb_en stays 0 (rd==0 suppression).
- lw, TIMEOUT=8, memory never ready -> err_timeout pulses once after 8 cycles, no wb, next add retires normally.
- Illegal opcode 4'b1111 -> err_illegal pulse, no wb. Separately, reset_n asserted while in RESP -> dmem_req and wb_en 0 immediately, a later rvalid is ignored.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU definitions: opcodes, memory-stage states, register constants.
package cpu_pkg;

   localparam logic [3:0] OP_LW   = 4'b0000;
   localparam logic [3:0] OP_SW   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0101;
   localparam logic [3:0] OP_ADDI = 4'b1000;

   localparam logic [3:0] REG_ZERO = 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   // True for operations that retire straight from the ALU result.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
   endfunction

   // True for operations that need the data-memory port.
   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory valid/ready port; master is the stage, slave is the memory.
interface mem_wb_stage_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              dmem_req;
   logic              dmem_ready;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_rvalid;
   logic [DATA_W-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ready, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ready, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_wb_stage_timeout_ctr.sv
// Access timeout counter: clear restarts at zero, enable counts up,
// expired flags the last allowed cycle (count == TIMEOUT-1).
module mem_timeout_ctr #(
   parameter int TIMEOUT = 32
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int               CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, then count up while enabled and below the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && (cnt_q != LIMIT))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: ALU ops retire in one cycle, loads and
// stores use the valid/ready data-memory port with a response timeout.
module mem_wb_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   // ALU stage handshake
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_opcode,
   input  logic [3:0]        in_rd,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_store_data,
   input  logic [7:0]        in_pc,
   // Data memory
   mem_wb_stage_if.master    dmem,
   // Register-file write port
   output logic              wb_en,
   output logic [3:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [7:0]        wb_pc,
   // Error pulses
   output logic              err_timeout,
   output logic              err_illegal
);

   mem_state_t        state_q, state_d;
   logic [3:0]        rd_q, rd_d;
   logic [7:0]        pc_q, pc_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wb_en_q, wb_en_d;
   logic [3:0]        wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [7:0]        wb_pc_q, wb_pc_d;
   logic              err_to_q, err_to_d;
   logic              err_il_q, err_il_d;

   logic              ctr_clear, ctr_en, ctr_expired;
   logic              load_done, store_done;

   // Only the low ADDR_W bits of the effective address reach the memory.
   logic unused_addr_hi;
   assign unused_addr_hi = ^in_alu_result[DATA_W-1:ADDR_W];

   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (ctr_clear),
      .enable  (ctr_en),
      .expired (ctr_expired)
   );

   assign in_ready = (state_q == IDLE);

   // Completion conditions; a load may finish in REQ if rvalid rides with ready.
   assign store_done = (state_q == REQ) && req_q && dmem.dmem_ready && we_q;
   assign load_done  = ((state_q == REQ) && req_q && dmem.dmem_ready && !we_q && dmem.dmem_rvalid)
                    || ((state_q == RESP) && dmem.dmem_rvalid);

   // Next-state and registered-output logic.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; that is what keeps this block free of inferred latches.
      state_d   = state_q;
      rd_d      = rd_q;
      pc_d      = pc_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wb_en_d   = 1'b0;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      wb_pc_d   = wb_pc_q;
      err_to_d  = 1'b0;
      err_il_d  = 1'b0;
      ctr_clear = 1'b0;
      ctr_en    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (is_alu_op(in_opcode)) begin
                  wb_en_d   = (in_rd != REG_ZERO);
                  wb_addr_d = in_rd;
                  wb_data_d = in_alu_result;
                  wb_pc_d   = in_pc;
               end else if (is_mem_op(in_opcode)) begin
                  rd_d      = in_rd;
                  pc_d      = in_pc;
                  addr_d    = in_alu_result[ADDR_W-1:0];
                  wdata_d   = in_store_data;
                  we_d      = (in_opcode == OP_SW);
                  req_d     = 1'b1;
                  ctr_clear = 1'b1;
                  state_d   = REQ;
               end else begin
                  err_il_d = 1'b1;
               end
            end
         end

         REQ, RESP: begin
            ctr_en = 1'b1;
            if (store_done) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end else if (load_done) begin
               req_d     = 1'b0;
               wb_en_d   = (rd_q != REG_ZERO);
               wb_addr_d = rd_q;
               wb_data_d = dmem.dmem_rdata;
               wb_pc_d   = pc_q;
               state_d   = IDLE;
            end else if (ctr_expired) begin
               req_d    = 1'b0;
               err_to_d = 1'b1;
               state_d  = IDLE;
            end else if (state_q == REQ && dmem.dmem_ready) begin
               req_d   = 1'b0;
               state_d = RESP;
            end
         end

         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         rd_q      <= '0;
         pc_q      <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         wb_pc_q   <= '0;
         err_to_q  <= 1'b0;
         err_il_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q   <= state_d;
         rd_q      <= rd_d;
         pc_q      <= pc_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wb_en_q   <= wb_en_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         wb_pc_q   <= wb_pc_d;
         err_to_q  <= err_to_d;
         err_il_q  <= err_il_d;
      end
   end

   assign dmem.dmem_req   = req_q;
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;
   assign wb_en           = wb_en_q;
   assign wb_addr         = wb_addr_q;
   assign wb_data         = wb_data_q;
   assign wb_pc           = wb_pc_q;
   assign err_timeout     = err_to_q;
   assign err_illegal     = err_il_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with TIMEOUT=8; inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_mem_wb_stage;
   import cpu_pkg::*;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 8;

   logic              clk;
   logic              reset_n;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_opcode;
   logic [3:0]        in_rd;
   logic [DATA_W-1:0] in_alu_result;
   logic [DATA_W-1:0] in_store_data;
   logic [7:0]        in_pc;
   logic              wb_en;
   logic [3:0]        wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [7:0]        wb_pc;
   logic              err_timeout;
   logic              err_illegal;

   int checks = 0;
   int errors = 0;

   mem_wb_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dmem_if ();

   mem_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_opcode     (in_opcode),
      .in_rd         (in_rd),
      .in_alu_result (in_alu_result),
      .in_store_data (in_store_data),
      .in_pc         (in_pc),
      .dmem          (dmem_if),
      .wb_en         (wb_en),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .wb_pc         (wb_pc),
      .err_timeout   (err_timeout),
      .err_illegal   (err_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rd,
                        input logic [15:0] res, input logic [15:0] sd, input logic [7:0] pc);
      in_valid      = v;
      in_opcode     = op;
      in_rd         = rd;
      in_alu_result = res;
      in_store_data = sd;
      in_pc         = pc;
   endtask

   initial begin
      reset_n             = 1'b0;
      drive(1'b0, OP_ADD, 4'd0, 16'h0, 16'h0, 8'h0);
      dmem_if.dmem_ready  = 1'b0;
      dmem_if.dmem_rvalid = 1'b0;
      dmem_if.dmem_rdata  = '0;

      // Reset state
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_req", dmem_if.dmem_req, 0);
      check("rst_we", dmem_if.dmem_we, 0);
      check("rst_addr", dmem_if.dmem_addr, 0);
      check("rst_wb_en", wb_en, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_errs", {err_timeout, err_illegal}, 0);
      tick();
      reset_n = 1'b1;
      tick();

      // Back-to-back ALU ops
      drive(1'b1, OP_ADD, 4'd3, 16'h0005, 16'h0, 8'h10);
      check("alu1_ready", in_ready, 1);
      tick();
      check("alu1_wb", {wb_en, wb_addr, wb_data, wb_pc}, {1'b1, 4'd3, 16'h0005, 8'h10});
      drive(1'b1, OP_SUB, 4'd4, 16'hFFFF, 16'h0, 8'h11);
      check("alu2_ready", in_ready, 1);
      tick();
      check("alu2_wb", {wb_en, wb_addr, wb_data, wb_pc}, {1'b1, 4'd4, 16'hFFFF, 8'h11});
      drive(1'b0, OP_ADD, 4'd0, 16'h0, 16'h0, 8'h0);
      tick();
      check("alu_idle_wb", {wb_en, wb_data}, {1'b0, 16'hFFFF});

      // Load with delayed ready and delayed rvalid
      drive(1'b1, OP_LW, 4'd5, 16'h0130, 16'hAAAA, 8'h20);
      tick();
      drive(1'b0, OP_ADD, 4'd0, 16'h0, 16'h0, 8'h0);
      check("lw_req", {dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr}, {1'b1, 1'b0, 8'h30});
      check("lw_ready_low", in_ready, 0);
      tick();
      check("lw_req_hold", {dmem_if.dmem_req, dmem_if.dmem_addr}, {1'b1, 8'h30});
      dmem_if.dmem_ready = 1'b1;
      tick();
      dmem_if.dmem_ready = 1'b0;
      check("lw_resp_req", dmem_if.dmem_req, 0);
      check("lw_resp_busy", in_ready, 0);
      tick();
      tick();
      check("lw_wait", {in_ready, wb_en}, {1'b0, 1'b0});
      dmem_if.dmem_rvalid = 1'b1;
      dmem_if.dmem_rdata  = 16'h000B;
      tick();
      dmem_if.dmem_rvalid = 1'b0;
      check("lw_wb", {wb_en, wb_addr, wb_data, wb_pc}, {1'b1, 4'd5, 16'h000B, 8'h20});
      check("lw_done_ready", in_ready, 1);
      tick();
      check("lw_wb_pulse", wb_en, 0);

      // Store accepted in its first request cycle
      drive(1'b1, OP_SW, 4'd1, 16'h0031, 16'h1234, 8'h30);
      tick();
      drive(1'b0, OP_ADD, 4'd0, 16'h0, 16'h0, 8'h0);
      check("sw_req", {dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata},
            {1'b1, 1'b1, 8'h31, 16'h1234});
      dmem_if.dmem_ready  = 1'b1;
      dmem_if.dmem_rvalid = 1'b1;   // ignored for a store
      dmem_if.dmem_rdata  = 16'h5555;
      tick();
      dmem_if.dmem_ready  = 1'b0;
      dmem_if.dmem_rvalid = 1'b0;
      check("sw_done", {dmem_if.dmem_req, wb_en, in_ready}, {1'b0, 1'b0, 1'b1});
      check("sw_no_wbdata", wb_data, 16'h000B);

      // Load to r0 completing in the request cycle
      drive(1'b1, OP_LW, 4'd0, 16'h0040, 16'h0, 8'h40);
      tick();
      drive(1'b0, OP_ADD, 4'd0, 16'h0, 16'h0, 8'h0);
      dmem_if.dmem_ready  = 1'b1;
      dmem_if.dmem_rvalid = 1'b1;
      dmem_if.dmem_rdata  = 16'hBEEF;
      tick();
      dmem_if.dmem_ready  = 1'b0;
      dmem_if.dmem_rvalid = 1'b0;
      check("lw0_state", {in_ready, dmem_if.dmem_req}, {1'b1, 1'b0});
      check("lw0_wb", {wb_en, wb_data, wb_pc}, {1'b0, 16'hBEEF, 8'h40});

      // Timeout: memory never ready
      drive(1'b1, OP_LW, 4'd6, 16'h0050, 16'h0, 8'h50);
      tick();
      drive(1'b0, OP_ADD, 4'd0, 16'h0, 16'h0, 8'h0);
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         check("to_wait", {dmem_if.dmem_req, err_timeout, in_ready}, {1'b1, 1'b0, 1'b0});
         tick();
      end
      check("to_last", {dmem_if.dmem_req, err_timeout}, {1'b1, 1'b0});
      tick();
      check("to_abort", {err_timeout, dmem_if.dmem_req, wb_en, in_ready}, {1'b1, 1'b0, 1'b0, 1'b1});
      drive(1'b1, OP_ADD, 4'd7, 16'h0077, 16'h0, 8'h51);
      tick();
      drive(1'b0, OP_ADD, 4'd0, 16'h0, 16'h0, 8'h0);
      check("to_pulse", err_timeout, 0);
      check("to_add_wb", {wb_en, wb_addr, wb_data, wb_pc}, {1'b1, 4'd7, 16'h0077, 8'h51});

      // Illegal opcode
      drive(1'b1, 4'b1111, 4'd8, 16'h0088, 16'h0, 8'h60);
      tick();
      drive(1'b0, OP_ADD, 4'd0, 16'h0, 16'h0, 8'h0);
      check("ill_pulse", {err_illegal, wb_en, in_ready}, {1'b1, 1'b0, 1'b1});
      check("ill_wb_hold", wb_data, 16'h0077);
      tick();
      check("ill_clear", err_illegal, 0);

      // Reset while waiting in RESP
      drive(1'b1, OP_LW, 4'd9, 16'h0060, 16'h0, 8'h70);
      tick();
      drive(1'b0, OP_ADD, 4'd0, 16'h0, 16'h0, 8'h0);
      check("rr_req", dmem_if.dmem_req, 1);
      dmem_if.dmem_ready = 1'b1;
      tick();
      dmem_if.dmem_ready = 1'b0;
      check("rr_in_resp", {in_ready, dmem_if.dmem_req}, {1'b0, 1'b0});
      #2;
      reset_n = 1'b0;
      #1;
      check("rr_async", {dmem_if.dmem_req, wb_en, in_ready, dmem_if.dmem_addr}, {1'b0, 1'b0, 1'b1, 8'h00});
      #1;
      reset_n = 1'b1;
      dmem_if.dmem_rvalid = 1'b1;
      dmem_if.dmem_rdata  = 16'h1111;
      tick();
      dmem_if.dmem_rvalid = 1'b0;
      check("rr_rvalid_ignored", {wb_en, wb_data, in_ready}, {1'b0, 16'h0000, 1'b1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
